// File: rtl/adder_pkg.sv
// rtl/adder_pkg.sv - shared types and constants for the chunked sequential adder
// Contents:
//   CHUNK_W   : bits handled by the ripple slice per cycle
//   state_t   : controller FSM states
//   cnt_width : chunk-counter width for a given chunk count (never below 1)
package adder_pkg;

  localparam int CHUNK_W = 3;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_RUN  = 2'd1,
    ST_DONE = 2'd2
  } state_t;

  function automatic int cnt_width(input int n);
    if (n <= 2) return 1;
    return $clog2(n);
  endfunction

endpackage

// File: rtl/adder_slice3.sv
// rtl/adder_slice3.sv - combinational 3-bit ripple adder slice in AND/NOT form
// Ports:
//   x, y : 3-bit addend chunks
//   ci   : carry into bit 0
//   s    : 3-bit chunk sum
//   co   : carry out of bit 2
module adder_slice3 (
  input  logic [2:0] x,
  input  logic [2:0] y,
  input  logic       ci,
  output logic [2:0] s,
  output logic       co
);

  logic [3:0] c;

  assign c[0] = ci;

  // Only AND and NOT gates are used so an approximate slice with the same
  // gate vocabulary can replace this one without touching the controller.
  genvar i;
  generate
    for (i = 0; i < 3; i++) begin : g_bit
      logic p;
      assign p      = ~(~(x[i] & ~y[i]) & ~(~x[i] & y[i]));
      assign s[i]   = ~(~(p & ~c[i]) & ~(~p & c[i]));
      // carry = majority(x, y, c)
      assign c[i+1] = ~(~(x[i] & y[i]) & ~(x[i] & c[i]) & ~(y[i] & c[i]));
    end
  endgenerate

  assign co = c[3];

endmodule

// File: rtl/adder_seq_ctrl.sv
// rtl/adder_seq_ctrl.sv - WIDTH-bit a+b+cin computed 3 bits per cycle on one slice
// Ports:
//   clk, rst             : clock, synchronous active-high reset
//   in_valid / in_ready  : operand handshake (a, b, cin)
//   out_valid / out_ready: result handshake (sum, cout)
//   busy                 : an operation is in RUN or waiting in DONE
module adder_seq_ctrl #(
  parameter int WIDTH = 12
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic             cin,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] sum,
  output logic             cout,
  output logic             busy
);
  import adder_pkg::*;

  localparam int N  = WIDTH / CHUNK_W;
  localparam int CW = cnt_width(N);

  generate
    if (WIDTH < CHUNK_W || (WIDTH % CHUNK_W) != 0) begin : g_bad_width
      $error("adder_seq_ctrl: WIDTH must be a positive multiple of 3");
    end
  endgenerate

  state_t           state;
  logic [WIDTH-1:0] a_sh;
  logic [WIDTH-1:0] b_sh;
  logic [WIDTH-1:0] acc;
  logic [WIDTH-1:0] acc_next;
  logic [WIDTH-1:0] sum_q;
  logic             carry;
  logic             cout_q;
  logic [CW-1:0]    cnt;
  logic [2:0]       sl_s;
  logic             sl_co;
  logic             last;

  adder_slice3 u_slice (
    .x  (a_sh[2:0]),
    .y  (b_sh[2:0]),
    .ci (carry),
    .s  (sl_s),
    .co (sl_co)
  );

  assign last = (cnt == CW'(N - 1));

  // Chunks enter at the top and move down, so after N shifts the first
  // (least-significant) chunk sits at bit 0.
  assign acc_next = (acc >> CHUNK_W) | (WIDTH'(sl_s) << (WIDTH - CHUNK_W));

  always_ff @(posedge clk) begin
    if (rst) begin
      state  <= ST_IDLE;
      a_sh   <= '0;
      b_sh   <= '0;
      acc    <= '0;
      sum_q  <= '0;
      carry  <= 1'b0;
      cout_q <= 1'b0;
      cnt    <= '0;
    end else begin
      case (state)
        ST_IDLE: begin
          if (in_valid) begin
            a_sh  <= a;
            b_sh  <= b;
            carry <= cin;
            cnt   <= '0;
            state <= ST_RUN;
          end
        end
        ST_RUN: begin
          a_sh  <= a_sh >> CHUNK_W;
          b_sh  <= b_sh >> CHUNK_W;
          acc   <= acc_next;
          carry <= sl_co;
          cnt   <= cnt + CW'(1);
          // Visible result registers move only here, so sum/cout never
          // show partially shifted values while RUN is in progress.
          if (last) begin
            sum_q  <= acc_next;
            cout_q <= sl_co;
            state  <= ST_DONE;
          end
        end
        ST_DONE: begin
          if (out_ready) state <= ST_IDLE;
        end
        default: state <= ST_IDLE;
      endcase
    end
  end

  assign in_ready  = (state == ST_IDLE);
  assign out_valid = (state == ST_DONE);
  assign busy      = (state != ST_IDLE);
  assign sum       = sum_q;
  assign cout      = cout_q;

endmodule

// File: tb/tb_adder_seq_ctrl.sv
// tb/tb_adder_seq_ctrl.sv - scoreboard bench for adder_seq_ctrl at WIDTH 12, 3 and 24
module tb_adder_seq_ctrl;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic        rst;
  logic        in_valid, in_ready, cin, out_valid, out_ready, cout, busy;
  logic [11:0] a, b, sum;

  logic        v3, ir3, c3, ov3, or3, co3, bz3;
  logic [2:0]  a3, b3, s3;
  logic        v24, ir24, c24, ov24, or24, co24, bz24;
  logic [23:0] a24, b24, s24;

  adder_seq_ctrl #(.WIDTH(12)) u_dut (
    .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready),
    .a(a), .b(b), .cin(cin), .out_valid(out_valid), .out_ready(out_ready),
    .sum(sum), .cout(cout), .busy(busy)
  );

  adder_seq_ctrl #(.WIDTH(3)) u_w3 (
    .clk(clk), .rst(rst), .in_valid(v3), .in_ready(ir3),
    .a(a3), .b(b3), .cin(c3), .out_valid(ov3), .out_ready(or3),
    .sum(s3), .cout(co3), .busy(bz3)
  );

  adder_seq_ctrl #(.WIDTH(24)) u_w24 (
    .clk(clk), .rst(rst), .in_valid(v24), .in_ready(ir24),
    .a(a24), .b(b24), .cin(c24), .out_valid(ov24), .out_ready(or24),
    .sum(s24), .cout(co24), .busy(bz24)
  );

  int tests  = 0;
  int fails  = 0;
  int n_out  = 0;
  int n_push = 0;
  int cyc    = 0;
  int acc_cyc;
  logic [12:0] exp_q[$];

  always @(posedge clk) cyc <= cyc + 1;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
    end
  endtask

  // Monitor: every completed output handshake is checked against the queue.
  always @(negedge clk) begin
    if (!rst && out_valid && out_ready) begin
      n_out++;
      if (exp_q.size() == 0) begin
        tests++;
        fails++;
        $display("FAIL unexpected_result: got 0x%0h with no expectation queued", {cout, sum});
      end else begin
        chk("result", {19'd0, cout, sum}, {19'd0, exp_q.pop_front()});
      end
    end
  end

  task automatic issue(input logic [11:0] av, input logic [11:0] bv, input logic cv, input bit push);
    int w;
    w = 0;
    a = av; b = bv; cin = cv; in_valid = 1'b1;
    if (push) begin
      exp_q.push_back({1'b0, av} + {1'b0, bv} + 13'(cv));
      n_push++;
    end
    @(negedge clk);
    while (!in_ready && w < 50) begin
      @(negedge clk);
      w++;
    end
    if (!in_ready) chk("accept_timeout", 32'(in_ready), 32'd1);
    @(posedge clk);
    #1;
    acc_cyc  = cyc;
    in_valid = 1'b0;
  endtask

  task automatic wait_valid(output int n);
    n = 0;
    while (!out_valid && n < 30) begin
      @(posedge clk);
      #1;
      n++;
    end
  endtask

  task automatic run3(input logic [2:0] av, input logic [2:0] bv, input logic cv, input logic [3:0] exp);
    int n;
    n = 0;
    a3 = av; b3 = bv; c3 = cv; v3 = 1'b1;
    @(negedge clk);
    while (!ir3 && n < 20) begin @(negedge clk); n++; end
    @(posedge clk);
    #1;
    v3 = 1'b0;
    n = 0;
    while (!ov3 && n < 20) begin @(posedge clk); #1; n++; end
    chk("w3_latency", 32'(n), 32'd1);
    chk("w3_result", {28'd0, co3, s3}, {28'd0, exp});
    @(posedge clk);
    #1;
  endtask

  task automatic run24(input logic [23:0] av, input logic [23:0] bv, input logic cv, input logic [24:0] exp);
    int n;
    n = 0;
    a24 = av; b24 = bv; c24 = cv; v24 = 1'b1;
    @(negedge clk);
    while (!ir24 && n < 20) begin @(negedge clk); n++; end
    @(posedge clk);
    #1;
    v24 = 1'b0;
    n = 0;
    while (!ov24 && n < 30) begin @(posedge clk); #1; n++; end
    chk("w24_latency", 32'(n), 32'd8);
    chk("w24_result", {7'd0, co24, s24}, {7'd0, exp});
    @(posedge clk);
    #1;
  endtask

  initial begin
    int n;
    int prev;
    logic [11:0] ra, rb;
    logic [23:0] qa, qb;
    logic [2:0]  ta, tb;
    logic        rc;

    rst = 1'b1; in_valid = 1'b0; out_ready = 1'b1; a = '0; b = '0; cin = 1'b0;
    v3 = 1'b0; or3 = 1'b1; a3 = '0; b3 = '0; c3 = 1'b0;
    v24 = 1'b0; or24 = 1'b1; a24 = '0; b24 = '0; c24 = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    rst = 1'b0;

    chk("reset_in_ready", 32'(in_ready), 32'd1);
    chk("reset_out_valid", 32'(out_valid), 32'd0);
    chk("reset_busy", 32'(busy), 32'd0);
    chk("reset_sum", 32'(sum), 32'd0);
    chk("reset_cout", 32'(cout), 32'd0);

    // 0xFFF + 0x001: carry ripples through every chunk
    issue(12'hFFF, 12'h001, 1'b0, 1'b1);
    wait_valid(n);
    chk("t1_latency", 32'(n), 32'd4);
    chk("t1_sum", 32'(sum), 32'h000);
    chk("t1_cout", 32'(cout), 32'd1);
    chk("t1_busy", 32'(busy), 32'd1);
    @(posedge clk);
    #1;

    // in_valid held high during RUN must not be captured again
    issue(12'h5A5, 12'h25B, 1'b1, 1'b1);
    in_valid = 1'b1;
    n = 0;
    while (!out_valid && n < 30) begin
      chk("run_in_ready", 32'(in_ready), 32'd0);
      @(posedge clk);
      #1;
      n++;
    end
    in_valid = 1'b0;
    chk("t2_latency", 32'(n), 32'd4);
    chk("t2_sum", 32'(sum), 32'h801);
    chk("t2_cout", 32'(cout), 32'd0);
    repeat (3) @(posedge clk);
    #1;
    chk("t2_no_recapture", 32'(busy), 32'd0);

    // backpressure: result must hold while out_ready is low
    out_ready = 1'b0;
    issue(12'h123, 12'h456, 1'b0, 1'b1);
    wait_valid(n);
    repeat (7) begin
      @(posedge clk);
      #1;
      chk("bp_out_valid", 32'(out_valid), 32'd1);
      chk("bp_sum", 32'(sum), 32'h579);
      chk("bp_cout", 32'(cout), 32'd0);
    end
    out_ready = 1'b1;
    @(posedge clk);
    #1;
    chk("bp_in_ready", 32'(in_ready), 32'd1);
    chk("bp_out_valid_low", 32'(out_valid), 32'd0);

    // reset after two chunks discards the operation
    issue(12'h7FF, 12'h7FF, 1'b1, 1'b0);
    repeat (2) @(posedge clk);
    #1;
    rst = 1'b1;
    @(posedge clk);
    #1;
    rst = 1'b0;
    chk("mid_rst_in_ready", 32'(in_ready), 32'd1);
    chk("mid_rst_out_valid", 32'(out_valid), 32'd0);
    chk("mid_rst_sum", 32'(sum), 32'd0);
    chk("mid_rst_cout", 32'(cout), 32'd0);
    chk("mid_rst_busy", 32'(busy), 32'd0);
    issue(12'h800, 12'h800, 1'b0, 1'b1);
    wait_valid(n);
    chk("post_rst_sum", 32'(sum), 32'h000);
    chk("post_rst_cout", 32'(cout), 32'd1);
    @(posedge clk);
    #1;

    // back-to-back random ops: each accepted N+2 cycles after the previous
    prev = 0;
    for (int i = 0; i < 200; i++) begin
      ra = 12'($urandom());
      rb = 12'($urandom());
      rc = 1'($urandom());
      issue(ra, rb, rc, 1'b1);
      if (i > 0) chk("b2b_spacing", 32'(acc_cyc - prev), 32'd6);
      prev = acc_cyc;
    end
    n = 0;
    while (exp_q.size() != 0 && n < 30) begin
      @(posedge clk);
      n++;
    end
    chk("queue_drained", 32'(exp_q.size()), 32'd0);
    chk("result_count", 32'(n_out), 32'(n_push));

    // WIDTH=3 (single chunk)
    run3(3'd7, 3'd7, 1'b1, 4'hF);
    run3(3'd0, 3'd0, 1'b0, 4'h0);
    run3(3'd5, 3'd2, 1'b1, 4'h8);
    for (int i = 0; i < 100; i++) begin
      ta = 3'($urandom());
      tb = 3'($urandom());
      rc = 1'($urandom());
      run3(ta, tb, rc, {1'b0, ta} + {1'b0, tb} + 4'(rc));
    end

    // WIDTH=24
    run24(24'hFFFFFF, 24'hFFFFFF, 1'b1, 25'h1FFFFFF);
    run24(24'h800000, 24'h800000, 1'b0, 25'h1000000);
    run24(24'h123456, 24'h654321, 1'b0, 25'h0777777);
    for (int i = 0; i < 100; i++) begin
      qa = 24'($urandom());
      qb = 24'($urandom());
      rc = 1'($urandom());
      run24(qa, qb, rc, {1'b0, qa} + {1'b0, qb} + 25'(rc));
    end

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
